// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM (1-cycle sync read) between host port A and FIR port B.
// Optional macro BRAM_ARB_PERF_EN adds perf_clr / conflict_cnt (dual-request arbitration counter).
module bram_port_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [3:0]        a_sel,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [3:0]        b_sel,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [31:0]       bram_a,
    output logic [DATA_W-1:0] bram_di,
    input  logic [DATA_W-1:0] bram_do
`ifdef BRAM_ARB_PERF_EN
   ,input  logic              perf_clr,
    output logic [15:0]       conflict_cnt
`endif
);
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned BRAM_AW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_b;
    logic   r_win_b;
    logic   r_win_we;

    logic              w_any_req;
    logic              w_pick_b;
    logic              w_we;
    logic [SEL_W-1:0]  w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // On a tie the port that did not win last time takes the BRAM.
    assign w_any_req = a_req | b_req;
    assign w_pick_b  = b_req & (~a_req | ~r_last_b);
    assign w_we      = w_pick_b ? b_we    : a_we;
    assign w_sel     = w_pick_b ? b_sel   : a_sel;
    assign w_addr    = w_pick_b ? b_addr  : a_addr;
    assign w_wdata   = w_pick_b ? b_wdata : a_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last_b <= 1'b1;
            r_win_b  <= 1'b0;
            r_win_we <= 1'b0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            rdata    <= '0;
            bram_en  <= 1'b0;
            bram_we  <= '0;
            bram_a   <= '0;
            bram_di  <= '0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        bram_en  <= 1'b1;
                        bram_we  <= w_we ? w_sel : SEL_W'(0);
                        bram_a   <= BRAM_AW'(w_addr);
                        bram_di  <= w_wdata;
                        a_gnt    <= ~w_pick_b;
                        b_gnt    <= w_pick_b;
                        r_last_b <= w_pick_b;
                        r_win_b  <= w_pick_b;
                        r_win_we <= w_we;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    // BRAM samples the op at the end of this cycle; address/data stay put.
                    bram_en <= 1'b0;
                    bram_we <= '0;
                    r_state <= r_win_we ? IDLE : RESP;
                end
                RESP: begin
                    rdata    <= bram_do;
                    a_rvalid <= ~r_win_b;
                    b_rvalid <= r_win_b;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BRAM_ARB_PERF_EN
    // Saturating count of arbitrations where both ports were contending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (perf_clr) begin
            conflict_cnt <= '0;
        end else if (r_state == IDLE && a_req && b_req && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule
